// File: rtl/mbe_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mbe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mbe_state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_dig_t;

  // One extra digit covers the top bit of the sign/zero-extended multiplier.
  function automatic int n_digits(input int width);
    return width / 2 + 1;
  endfunction

  // Radix-4 recoding of the overlapping triplet (b[2i+1], b[2i], b[2i-1]).
  function automatic booth_dig_t booth_encode(input logic [2:0] slice);
    case (slice)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/mbe_mpy_seq_if.sv
// Operand/result handshake bundle for mbe_mpy_seq.
interface mbe_mpy_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               SIGNED;
  logic               IN_VALID;
  logic               IN_READY;
  logic [2*WIDTH-1:0] MPY_OUT;
  logic               OUT_VALID;
  logic               OUT_READY;

  modport master (
    output A, B, SIGNED, IN_VALID, OUT_READY,
    input  IN_READY, MPY_OUT, OUT_VALID
  );

  modport slave (
    input  A, B, SIGNED, IN_VALID, OUT_READY,
    output IN_READY, MPY_OUT, OUT_VALID
  );
endinterface

// File: rtl/mbe_booth_sel.sv
// Booth digit selector: turns a 3-bit multiplier slice into a signed
// partial product of the extended multiplicand.
module mbe_booth_sel
  import mbe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              [2:0]       b_slice,
  input  logic signed       [WIDTH+1:0] a_ext,
  output logic signed       [WIDTH+2:0] pp
);

  booth_dig_t              dig;
  logic signed [WIDTH+2:0] a_x1;
  logic signed [WIDTH+2:0] a_x2;

  // Pick 0, +/-A or +/-2A; 2A still fits because |A| <= 2^WIDTH.
  always_comb begin
    dig  = booth_encode(b_slice);
    a_x1 = {a_ext[WIDTH+1], a_ext};
    a_x2 = {a_ext, 1'b0};
    pp   = '0;
    case (dig)
      POS1:    pp = a_x1;
      POS2:    pp = a_x2;
      NEG1:    pp = -a_x1;
      NEG2:    pp = -a_x2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/mbe_mpy_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or
// unsigned per operation.
//
//   state | meaning
//   IDLE  | ready for a new operand pair, last result held on MPY_OUT
//   BUSY  | retiring one Booth digit per cycle
//   DONE  | result presented, waiting for OUT_READY
module mbe_mpy_seq
  import mbe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RST_n,
  mbe_mpy_seq_if.slave bus
);

  localparam int N  = n_digits(WIDTH);
  localparam int CW = $clog2(N);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 3;

  mbe_state_t state_q;
  mbe_state_t state_d;

  logic        [CW-1:0]      cnt_q;
  logic signed [XW-1:0]      a_q;
  logic signed [XW-1:0]      b_q;
  logic                      b_prev_q;
  logic signed [AW-1:0]      acc_q;
  logic        [WIDTH-1:0]   lo_q;
  logic        [2*WIDTH-1:0] mpy_q;

  logic                      accept;
  logic                      last_dig;
  logic        [XW-1:0]      a_in_ext;
  logic        [XW-1:0]      b_in_ext;
  logic        [2:0]         b_slice;
  logic signed [AW-1:0]      pp;
  logic signed [AW-1:0]      sum;
  logic signed [AW-1:0]      acc_shr;
  logic        [XW-1:0]      lo_nxt;

  assign accept   = (state_q == IDLE) && bus.IN_VALID;
  assign last_dig = (state_q == BUSY) && (cnt_q == CW'(N - 1));

  assign a_in_ext = bus.SIGNED ? {{2{bus.A[WIDTH-1]}}, bus.A} : {2'b00, bus.A};
  assign b_in_ext = bus.SIGNED ? {{2{bus.B[WIDTH-1]}}, bus.B} : {2'b00, bus.B};

  // b_q is shifted right two bits per digit, so the current triplet is
  // always its two LSBs plus the bit shifted out last time.
  assign b_slice = {b_q[1:0], b_prev_q};

  mbe_booth_sel #(.WIDTH(WIDTH)) u_booth_sel (
    .b_slice (b_slice),
    .a_ext   (a_q),
    .pp      (pp)
  );

  // Add-then-shift: two product bits retire into lo per digit.
  always_comb begin
    sum     = acc_q + pp;
    acc_shr = sum >>> 2;
    lo_nxt  = {sum[1:0], lo_q};
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d       = state_q;
    bus.IN_READY  = 1'b0;
    bus.OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        bus.IN_READY = 1'b1;
        if (bus.IN_VALID) state_d = BUSY;
      end
      BUSY: begin
        if (last_dig) state_d = DONE;
      end
      DONE: begin
        bus.OUT_VALID = 1'b1;
        if (bus.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, digit iteration and result latch.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      b_prev_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      mpy_q    <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      a_q      <= a_in_ext;
      b_q      <= b_in_ext;
      b_prev_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
    end else if (state_q == BUSY) begin
      cnt_q    <= cnt_q + CW'(1);
      b_q      <= b_q >>> 2;
      b_prev_q <= b_q[1];
      acc_q    <= acc_shr;
      lo_q     <= lo_nxt[XW-1:2];
      if (last_dig) mpy_q <= {acc_shr[WIDTH-3:0], lo_nxt};
    end
  end

  assign bus.MPY_OUT = mpy_q;

endmodule

// File: tb/tb_mbe_mpy_seq.sv
// Scoreboard bench for mbe_mpy_seq: 32-bit and 8-bit instances side by side.
module tb_mbe_mpy_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mbe_mpy_seq_if #(.WIDTH(32)) bus32 ();
  mbe_mpy_seq_if #(.WIDTH(8))  bus8 ();

  mbe_mpy_seq #(.WIDTH(32)) dut32 (.CLK(clk), .RST_n(rst_n), .bus(bus32.slave));
  mbe_mpy_seq #(.WIDTH(8))  dut8  (.CLK(clk), .RST_n(rst_n), .bus(bus8.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp32_q[$];
  logic [15:0] exp8_q[$];

  bit   stall32 = 1'b0, stall8 = 1'b0;
  logic rdy32 = 1'b0, rdy8 = 1'b0;
  logic rnd32 = 1'b1, rnd8 = 1'b1;

  assign bus32.OUT_READY = stall32 ? rnd32 : rdy32;
  assign bus8.OUT_READY  = stall8  ? rnd8  : rdy8;

  always @(posedge clk) begin
    #1;
    rnd32 = ($urandom_range(0, 3) != 0);
    rnd8  = ($urandom_range(0, 2) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Exact product from integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input bit sgn);
    longint sa, sb;
    logic [63:0] p, mask;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
    if (sgn) begin
      if (a[w-1]) sa = sa - longint'(64'h1 << w);
      if (b[w-1]) sb = sb - longint'(64'h1 << w);
    end
    p    = 64'(sa * sb);
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (2 * w)) - 64'h1);
    return p & mask;
  endfunction

  // Monitors: pop the expected result whenever a result handshake happens.
  always @(negedge clk) begin
    if (rst_n && bus32.OUT_VALID && bus32.OUT_READY) begin
      if (exp32_q.size() == 0) fail_note("unexpected_out32: result with nothing pending");
      else check("result32", bus32.MPY_OUT, exp32_q.pop_front());
    end
    if (rst_n && bus8.OUT_VALID && bus8.OUT_READY) begin
      if (exp8_q.size() == 0) fail_note("unexpected_out8: result with nothing pending");
      else check("result8", {48'b0, bus8.MPY_OUT}, {48'b0, exp8_q.pop_front()});
    end
  end

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [63:0] exp, input bit push);
    int cyc = 0;
    bit ok  = 1'b0;
    bus32.A = a; bus32.B = b; bus32.SIGNED = s; bus32.IN_VALID = 1'b1;
    while (!ok && cyc < 500) begin
      @(negedge clk);
      ok = bus32.IN_READY && rst_n;
      @(posedge clk);
      cyc++;
      if (ok && push) exp32_q.push_back(exp);
    end
    #1;
    bus32.IN_VALID = 1'b0;
    bus32.A = $urandom; bus32.B = $urandom; bus32.SIGNED = 1'($urandom);
    if (!ok) fail_note("accept32 timeout");
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s,
                        input logic [15:0] exp, input bit push);
    int cyc = 0;
    bit ok  = 1'b0;
    bus8.A = a; bus8.B = b; bus8.SIGNED = s; bus8.IN_VALID = 1'b1;
    while (!ok && cyc < 500) begin
      @(negedge clk);
      ok = bus8.IN_READY && rst_n;
      @(posedge clk);
      cyc++;
      if (ok && push) exp8_q.push_back(exp);
    end
    #1;
    bus8.IN_VALID = 1'b0;
    bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.SIGNED = 1'($urandom);
    if (!ok) fail_note("accept8 timeout");
  endtask

  // Directed op with OUT_READY held high: OUT_VALID exactly 17 edges after acceptance.
  task automatic lat32(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input logic [63:0] exp);
    issue32(a, b, s, exp, 1'b1);
    repeat (16) @(posedge clk);
    #1 check("lat32_early", 64'(bus32.OUT_VALID), 64'd0);
    @(posedge clk);
    #1 check("lat32_valid", 64'(bus32.OUT_VALID), 64'd1);
    @(posedge clk);
    #1 check("done32_one_cycle", 64'(bus32.OUT_VALID), 64'd0);
    check("ready32_after_out", 64'(bus32.IN_READY), 64'd1);
  endtask

  task automatic lat8(input logic [7:0] a, input logic [7:0] b, input bit s,
                      input logic [15:0] exp);
    issue8(a, b, s, exp, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("lat8_early", 64'(bus8.OUT_VALID), 64'd0);
    @(posedge clk);
    #1 check("lat8_valid", 64'(bus8.OUT_VALID), 64'd1);
    @(posedge clk);
    #1 check("ready8_after_out", 64'(bus8.IN_READY), 64'd1);
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rand32(input int n);
    logic [31:0] a, b;
    bit s;
    for (int i = 0; i < n; i++) begin
      a = pick32(); b = pick32(); s = 1'($urandom_range(0, 1));
      issue32(a, b, s, ref_mul(32, a, b, s), 1'b1);
    end
  endtask

  task automatic rand8(input int n);
    logic [7:0]  a, b;
    logic [63:0] full;
    bit s;
    for (int j = 0; j < n; j++) begin
      a = pick8(); b = pick8(); s = 1'($urandom_range(0, 1));
      full = ref_mul(8, {24'b0, a}, {24'b0, b}, s);
      issue8(a, b, s, full[15:0], 1'b1);
    end
  endtask

  initial begin
    logic [63:0] bp_exp;
    bit          seen;
    int          cyc;

    rst_n = 1'b0;
    bus32.A = '0; bus32.B = '0; bus32.SIGNED = 1'b0; bus32.IN_VALID = 1'b1;
    bus8.A  = '0; bus8.B  = '0; bus8.SIGNED  = 1'b0; bus8.IN_VALID  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready32", 64'(bus32.IN_READY), 64'd1);
    check("rst_out_valid32", 64'(bus32.OUT_VALID), 64'd0);
    check("rst_mpy32", bus32.MPY_OUT, 64'd0);
    check("rst_in_ready8", 64'(bus8.IN_READY), 64'd1);
    check("rst_out_valid8", 64'(bus8.OUT_VALID), 64'd0);
    check("rst_mpy8", 64'(bus8.MPY_OUT), 64'd0);
    bus32.IN_VALID = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_handshake_ignored", 64'(bus32.IN_READY), 64'd1);

    rdy32 = 1'b1;
    rdy8  = 1'b1;

    lat32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    lat32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    lat32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    lat32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
    lat32(32'h0000_0000, 32'h8000_0000, 1'b1, 64'h0);

    lat8(8'd200, 8'd250, 1'b0, 16'hC350);
    lat8(8'h80,  8'h80,  1'b1, 16'h4000);
    lat8(8'hFF,  8'h7F,  1'b1, 16'hFF81);

    // Backpressure: result must hold and a stray IN_VALID must be ignored.
    rdy32  = 1'b0;
    bp_exp = ref_mul(32, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    issue32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, bp_exp, 1'b1);
    cyc = 0;
    while (!bus32.OUT_VALID && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!bus32.OUT_VALID) fail_note("bp_wait_valid timeout");
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 64'(bus32.OUT_VALID), 64'd1);
      check("bp_mpy_hold", bus32.MPY_OUT, bp_exp);
      check("bp_in_ready", 64'(bus32.IN_READY), 64'd0);
      if (k == 1) begin
        bus32.A = 32'd7; bus32.B = 32'd9; bus32.SIGNED = 1'b0; bus32.IN_VALID = 1'b1;
      end
      if (k == 3) bus32.IN_VALID = 1'b0;
      @(posedge clk);
      #1;
    end
    rdy32 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(bus32.OUT_VALID), 64'd0);
    check("bp_release_ready", 64'(bus32.IN_READY), 64'd1);
    repeat (3) @(posedge clk);
    #1 check("bp_pulse_not_taken", 64'(bus32.IN_READY), 64'd1);

    // Reset during the 8th BUSY cycle aborts the operation.
    issue32(32'h0000_DEAD, 32'h0000_1234, 1'b0, 64'd0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_in_ready", 64'(bus32.IN_READY), 64'd1);
    check("abort_out_valid", 64'(bus32.OUT_VALID), 64'd0);
    check("abort_mpy32", bus32.MPY_OUT, 64'd0);
    check("abort_mpy8", 64'(bus8.MPY_OUT), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1 if (bus32.OUT_VALID) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    lat32(32'd3, 32'd5, 1'b0, 64'd15);

    // Random back-to-back traffic on both widths with output stalls.
    stall32 = 1'b1;
    stall8  = 1'b1;
    fork
      rand32(300);
      rand8(300);
    join
    stall32 = 1'b0;
    stall8  = 1'b0;
    cyc = 0;
    while ((exp32_q.size() != 0 || exp8_q.size() != 0) && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("drain32", 64'(exp32_q.size()), 64'd0);
    check("drain8", 64'(exp8_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
